// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-zero constant, ALU op width, the
// EX-stage control bundle and its NOP value, and the source-match helper.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         ALUOP_WIDTH = 2;

  // Control bits that travel with an instruction into EX (and onward to MEM).
  typedef struct packed {
    logic                   regWrite;
    logic                   memRead;
    logic                   memWrite;
    logic                   memToReg;
    logic                   aluSrc;
    logic [ALUOP_WIDTH-1:0] aluOp;
  } ctrl_t;

  // A bubble carries no side effects: every control bit low.
  localparam ctrl_t NOP_CTRL = '0;

  // True when a producer destination r is read by the instruction in ID.
  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic src_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       rt_used);
    return (r != REG_ZERO) && ((r == rs) || (rt_used && (r == rt)));
  endfunction

endpackage

// File: rtl/id_ex_hazard_if.sv
// Bundle of the ID-side inputs, MEM-side hazard inputs and EX-side outputs
// of the ID/EX register.
//
// Flow control: there is no valid/ready pair. The stage advances on every
// clock edge; stall=1 means the ID instruction cannot proceed this cycle, so
// the fetch side must hold (pcWrite=ifIdWrite=0) and EX receives a bubble.
interface id_ex_hazard_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
);
  // decode-side inputs
  logic [DATA_WIDTH-1:0] pcPlus4ID, readData1ID, readData2ID, immID;
  logic [4:0]            registerRsID, registerRtID, registerRdID;
  logic                  rtUsedID;
  logic                  regWriteID, memReadID, memWriteID, memToRegID;
  logic                  aluSrcID, regDstID, branchID;
  logic [1:0]            aluOpID;
  logic                  flushID;
  // MEM-stage producer
  logic                  memReadMEM;
  logic [4:0]            registerRdMEM;
  // EX-stage outputs
  logic [DATA_WIDTH-1:0] pcPlus4EX, readData1EX, readData2EX, immEX;
  logic [4:0]            registerRsEX, registerRtEX, registerRdEX;
  logic                  regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX;
  logic [1:0]            aluOpEX;
  // hazard outputs
  logic                  pcWrite, ifIdWrite, stall;
  logic [STALL_CNT_WIDTH-1:0] stallCount;

  // Decode/fetch side: drives ID and MEM inputs, observes EX and hazard outputs.
  modport master (
    output pcPlus4ID, readData1ID, readData2ID, immID,
    output registerRsID, registerRtID, registerRdID, rtUsedID,
    output regWriteID, memReadID, memWriteID, memToRegID, aluSrcID, regDstID,
    output branchID, aluOpID, flushID, memReadMEM, registerRdMEM,
    input  pcPlus4EX, readData1EX, readData2EX, immEX,
    input  registerRsEX, registerRtEX, registerRdEX,
    input  regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX, aluOpEX,
    input  pcWrite, ifIdWrite, stall, stallCount
  );

  // The ID/EX register itself.
  modport slave (
    input  pcPlus4ID, readData1ID, readData2ID, immID,
    input  registerRsID, registerRtID, registerRdID, rtUsedID,
    input  regWriteID, memReadID, memWriteID, memToRegID, aluSrcID, regDstID,
    input  branchID, aluOpID, flushID, memReadMEM, registerRdMEM,
    output pcPlus4EX, readData1EX, readData2EX, immEX,
    output registerRsEX, registerRtEX, registerRdEX,
    output regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX, aluOpEX,
    output pcWrite, ifIdWrite, stall, stallCount
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard detection for dependencies that forwarding cannot
// resolve: load-use, branch on a fresh ALU result, branch on a load in MEM.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       reset_i,
  input  logic       flush_i,
  input  logic       branch_id_i,
  input  logic       rt_used_id_i,
  input  logic [4:0] rs_id_i,
  input  logic [4:0] rt_id_i,
  input  logic       mem_read_ex_i,
  input  logic       reg_write_ex_i,
  input  logic [4:0] rd_ex_i,
  input  logic       mem_read_mem_i,
  input  logic [4:0] rd_mem_i,
  output logic       stall_o
);

  logic load_use;
  logic branch_alu;
  logic branch_load;

  // Hazard equations; a squashed instruction or a core in reset never stalls.
  always_comb begin
    load_use    = mem_read_ex_i && src_match(rd_ex_i, rs_id_i, rt_id_i, rt_used_id_i);
    branch_alu  = branch_id_i && reg_write_ex_i && !mem_read_ex_i &&
                  src_match(rd_ex_i, rs_id_i, rt_id_i, rt_used_id_i);
    branch_load = branch_id_i && mem_read_mem_i &&
                  src_match(rd_mem_i, rs_id_i, rt_id_i, rt_used_id_i);
    stall_o     = !reset_i && !flush_i && (load_use || branch_alu || branch_load);
  end

endmodule

// File: rtl/id_ex_hazard.sv
// ID/EX pipeline register with bubble insertion on stall or flush, hazard
// outputs for the fetch side, and a saturating stall-cycle counter.
module id_ex_hazard
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  id_ex_hazard_if.slave bus
);

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]            rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [STALL_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  stall;
  logic                  bubble;

  hazard_detect u_hazard (
    .reset_i        (reset),
    .flush_i        (bus.flushID),
    .branch_id_i    (bus.branchID),
    .rt_used_id_i   (bus.rtUsedID),
    .rs_id_i        (bus.registerRsID),
    .rt_id_i        (bus.registerRtID),
    .mem_read_ex_i  (ctrl_q.memRead),
    .reg_write_ex_i (ctrl_q.regWrite),
    .rd_ex_i        (rd_q),
    .mem_read_mem_i (bus.memReadMEM),
    .rd_mem_i       (bus.registerRdMEM),
    .stall_o        (stall)
  );

  assign bubble = stall || bus.flushID;

  // Next EX contents: the ID instruction, or an all-zero NOP on stall/flush.
  always_comb begin
    pc_d            = bus.pcPlus4ID;
    rd1_d           = bus.readData1ID;
    rd2_d           = bus.readData2ID;
    imm_d           = bus.immID;
    rs_d            = bus.registerRsID;
    rt_d            = bus.registerRtID;
    rd_d            = bus.regDstID ? bus.registerRdID : bus.registerRtID;
    ctrl_d.regWrite = bus.regWriteID;
    ctrl_d.memRead  = bus.memReadID;
    ctrl_d.memWrite = bus.memWriteID;
    ctrl_d.memToReg = bus.memToRegID;
    ctrl_d.aluSrc   = bus.aluSrcID;
    ctrl_d.aluOp    = bus.aluOpID;
    if (bubble) begin
      pc_d   = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      rs_d   = REG_ZERO;
      rt_d   = REG_ZERO;
      rd_d   = REG_ZERO;
      ctrl_d = NOP_CTRL;
    end
  end

  // Stall counter saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
  end

  // EX register and counter; reset leaves a NOP in EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= REG_ZERO;
      rt_q   <= REG_ZERO;
      rd_q   <= REG_ZERO;
      ctrl_q <= NOP_CTRL;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.pcPlus4EX    = pc_q;
  assign bus.readData1EX  = rd1_q;
  assign bus.readData2EX  = rd2_q;
  assign bus.immEX        = imm_q;
  assign bus.registerRsEX = rs_q;
  assign bus.registerRtEX = rt_q;
  assign bus.registerRdEX = rd_q;
  assign bus.regWriteEX   = ctrl_q.regWrite;
  assign bus.memReadEX    = ctrl_q.memRead;
  assign bus.memWriteEX   = ctrl_q.memWrite;
  assign bus.memToRegEX   = ctrl_q.memToReg;
  assign bus.aluSrcEX     = ctrl_q.aluSrc;
  assign bus.aluOpEX      = ctrl_q.aluOp;
  assign bus.stall        = stall;
  assign bus.pcWrite      = !stall;
  assign bus.ifIdWrite    = !stall;
  assign bus.stallCount   = cnt_q;

endmodule

// File: doc/id_ex_hazard.md
# id_ex_hazard

ID/EX pipeline register for the 5-stage MIPS core, with load-use and branch-operand hazard detection. It sits between decode and execute. It latches decoded operands and control into the EX stage, and those EX register fields feed the forwarding unit. It also stalls PC and IF/ID, and inserts a bubble, whenever forwarding cannot resolve a dependency. A saturating stall-cycle counter is kept for performance debug.

## Interface
Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC+4 paths
- STALL_CNT_WIDTH, 16, width of the stall-cycle counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pcPlus4ID, readData1ID, readData2ID, immID  in  DATA_WIDTH  decoded ID values
- registerRsID, registerRtID, registerRdID  in  5  ID register fields
- rtUsedID  in  1  instruction reads rt as a source (R-type, beq, bne, sw)
- regWriteID, memReadID, memWriteID, memToRegID, aluSrcID, regDstID, branchID  in  1  ID control
- aluOpID  in  2  ALU op class
- flushID  in  1  squash the instruction currently in ID
- memReadMEM  in  1  instruction in MEM is a load
- registerRdMEM  in  5  destination of the instruction in MEM
- pcPlus4EX, readData1EX, readData2EX, immEX  out  DATA_WIDTH  registered
- registerRsEX, registerRtEX  out  5  registered source fields
- registerRdEX  out  5  registered destination, already regDst-muxed
- regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX  out  1  registered control
- aluOpEX  out  2  registered
- pcWrite, ifIdWrite  out  1  combinational; 0 means hold PC and IF/ID
- stall  out  1  combinational; a hazard is detected this cycle
- stallCount  out  STALL_CNT_WIDTH  saturating count of stall cycles

## Operation
- Destination mux at capture: registerRdEX <= regDstID ? registerRdID : registerRtID.
- srcMatch(r) = r != 0 && (r == registerRsID || (rtUsedID && r == registerRtID)).
- Load-use hazard: memReadEX && srcMatch(registerRdEX).
- Branch-ALU hazard: branchID && regWriteEX && !memReadEX && srcMatch(registerRdEX).
- Branch-load hazard: branchID && memReadMEM && srcMatch(registerRdMEM).
- stall = !flushID && (any hazard). A squashed instruction never stalls.
- pcWrite = ifIdWrite = !stall.
- Bubble: when stall or flushID is set, the next edge loads a NOP. All control outputs go to 0 and all register fields go to 0. Data fields are don't-care and are implemented as 0.
- Otherwise the next edge loads all ID fields unchanged.
- A branch that depends on a load in EX stalls for 2 cycles. This follows from the rules above: load-use fires first, then branch-load fires.
- stallCount increments on each edge where stall = 1. It saturates at all-ones and never wraps.

## Timing
- Capture latency: 1 cycle from ID inputs to EX outputs.
- stall, pcWrite and ifIdWrite are purely combinational from the current inputs and the EX registers. There is no added latency.
- Reset (asynchronous) clears all EX outputs and stallCount to 0.
- While reset is high, pcWrite = ifIdWrite = 1 and stall = 0, regardless of the other inputs.
- Reset deasserted mid-stall: the EX stage holds a NOP, so no stale stall carries over.
- flushID and a hazard in the same cycle: flush wins. A bubble is loaded, stall = 0, and stallCount is unchanged.
- Destination register 0 never creates a hazard.

## Structure
- Shared package pipeline_pkg holds:
  - REG_ZERO (5'd0)
  - ALUOP_WIDTH (2)
  - the NOP control bundle constant, which is also reused by the EX/MEM register
- One sub-module, hazard_detect: the purely combinational hazard equations producing stall.
- id_ex_hazard owns the registers, the bubble mux and the counter.

## Test plan
- Load-use: lw $8 in EX (memReadEX=1, registerRdEX=8), ID add with Rs=8 -> stall=1, pcWrite=0; next edge EX is NOP and stallCount goes 0->1.
- rt not used: same as load-use but ID addi with Rt=8, rtUsedID=0 -> stall=0 and the ID instruction is captured.
- Branch after lw: beq Rs=9 in ID, lw $9 in EX -> stall for exactly 2 cycles (load-use, then branch-load with registerRdMEM=9); stallCount=2.
- Branch after ALU op: add $10 in EX (regWriteEX=1), beq Rt=10 -> 1 stall cycle; with registerRdEX=0 instead -> no stall.
- Flush priority: load-use condition plus flushID=1 -> stall=0, pcWrite=1, NOP loaded, stallCount unchanged.
- Reset and saturation: preload stallCount to 0xFFFE and force a 3-cycle stall -> stallCount ends at 0xFFFF; assert reset mid-cycle -> all EX outputs and stallCount read 0 with no clock edge.
